mdio_resp: RTL and testbench

- PHY-side MDIO management responder: the far end of the MAC MDIO master (mdio_clk / mdio_in / mdio_out / mdio_out_en) routed through pinmux.
- Oversamples MDC in the mclk domain and decodes Clause-22 frames.
- Read/write frames are turned into single transactions on a local 16-bit register bus.
- Used in the chip-level MAC loopback/test harness and as a stand-in PHY management target.

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_resp_if.sv | 22 ++
 rtl/mdio_edge_sync.sv | 34 +++
 rtl/mdio_resp.sv | 252 +++++++++++++++++++++++++
 tb/tb_mdio_resp.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO management responder.
package mdio_pkg;

    localparam int PRE_CNT_W  = 6;
    localparam int BIT_CNT_W  = 6;
    localparam int FIELD_W    = 5;
    localparam int DATA_W     = 16;
    localparam int SKIP_RISES = 34;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_BITS  = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    typedef enum logic [3:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RDATA,
        S_WDATA,
        S_SKIP
    } state_t;

endpackage

// File: rtl/mdio_resp_if.sv
// Local 16-bit register bus between the MDIO responder and its register target.
interface mdio_resp_if;
    import mdio_pkg::*;

    logic                reg_cs;
    logic                reg_wr;
    logic [FIELD_W-1:0]  reg_addr;
    logic [DATA_W-1:0]   reg_wdata;
    logic [DATA_W-1:0]   reg_rdata;
    logic                reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );

endinterface

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the mclk domain and derives single-cycle MDC edge pulses.
module mdio_edge_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic mclk,
    input  logic reset,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_s
);

    logic [SYNC_STG-1:0] mdc_pipe;
    logic [SYNC_STG-1:0] mdio_pipe;
    logic                mdc_prev;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            mdc_pipe  <= '0;
            mdio_pipe <= '0;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_pipe  <= {mdc_pipe[SYNC_STG-2:0], mdc};
            mdio_pipe <= {mdio_pipe[SYNC_STG-2:0], mdio_i};
            mdc_prev  <= mdc_pipe[SYNC_STG-1];
        end
    end

    assign mdc_rise = mdc_pipe[SYNC_STG-1] & ~mdc_prev;
    assign mdc_fall = ~mdc_pipe[SYNC_STG-1] & mdc_prev;
    assign mdio_s   = mdio_pipe[SYNC_STG-1];

endmodule

// File: rtl/mdio_resp.sv
// Clause-22 MDIO responder: decodes frames sampled on MDC rise, turns them into
// register-bus transactions and drives read data back on MDC fall.
module mdio_resp
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_MIN  = 32,
    parameter int         SYNC_STG = 2
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    mdio_resp_if.master bus,
    output logic        frame_done,
    output logic        frame_err,
    output logic        rd_timeout
);

    localparam logic [PRE_CNT_W-1:0] PRE_MIN_C  = PRE_CNT_W'(PRE_MIN);
    localparam logic [BIT_CNT_W-1:0] FIELD_LAST = BIT_CNT_W'(FIELD_W - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST  = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_END   = BIT_CNT_W'(DATA_W);
    localparam logic [BIT_CNT_W-1:0] SKIP_LAST  = BIT_CNT_W'(SKIP_RISES - 1);

    logic mdc_rise, mdc_fall, mdio_s;

    mdio_edge_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .mclk     (mclk),
        .reset    (reset),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall),
        .mdio_s   (mdio_s)
    );

    state_t                 state, state_n;
    logic [PRE_CNT_W-1:0]   pre_cnt, pre_cnt_n;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]      shreg, shreg_n, shift_in;
    logic [DATA_W-1:0]      out_shift, out_shift_n, rd_word;
    logic [FIELD_W-1:0]     regad, regad_n;
    logic                   is_read, is_read_n;
    logic                   mdio_o_n, mdio_oe_n;
    logic                   done_n, err_n, timeout_n;
    logic                   issue_rd, issue_wr, rd_arm, rd_sample;
    logic                   rd_valid, rd_want;
    logic [DATA_W-1:0]      rd_data;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state      <= S_PRE;
            pre_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            out_shift  <= '0;
            regad      <= '0;
            is_read    <= 1'b0;
            mdio_o     <= 1'b0;
            mdio_oe    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rd_timeout <= 1'b0;
        end else begin
            state      <= state_n;
            pre_cnt    <= pre_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            out_shift  <= out_shift_n;
            regad      <= regad_n;
            is_read    <= is_read_n;
            mdio_o     <= mdio_o_n;
            mdio_oe    <= mdio_oe_n;
            frame_done <= done_n;
            frame_err  <= err_n;
            rd_timeout <= timeout_n;
        end
    end

    // Frame decode happens on MDC rise; the read-data path only moves on MDC fall.
    always_comb begin
        state_n     = state;
        pre_cnt_n   = pre_cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        out_shift_n = out_shift;
        regad_n     = regad;
        is_read_n   = is_read;
        mdio_o_n    = mdio_o;
        mdio_oe_n   = mdio_oe;
        done_n      = 1'b0;
        err_n       = 1'b0;
        timeout_n   = 1'b0;
        issue_rd    = 1'b0;
        issue_wr    = 1'b0;
        rd_arm      = 1'b0;
        rd_sample   = 1'b0;
        shift_in    = {shreg[DATA_W-2:0], mdio_s};
        rd_word     = rd_valid ? rd_data : '1;

        if (mdc_rise) begin
            case (state)
                S_PRE: begin
                    if (mdio_s) begin
                        if (pre_cnt != '1) pre_cnt_n = pre_cnt + 1'b1;
                    end else if (pre_cnt >= PRE_MIN_C) begin
                        state_n = S_ST;
                    end else begin
                        pre_cnt_n = '0;
                    end
                end
                S_ST: begin
                    bit_cnt_n = '0;
                    if ({1'b0, mdio_s} == ST_BITS) begin
                        state_n = S_OP;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_PRE;
                    end
                end
                S_OP: begin
                    shreg_n   = shift_in;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 6'd1) begin
                        bit_cnt_n = '0;
                        state_n   = S_PHYAD;
                        if (shift_in[1:0] == OP_READ) begin
                            is_read_n = 1'b1;
                        end else if (shift_in[1:0] == OP_WRITE) begin
                            is_read_n = 1'b0;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_PRE;
                        end
                    end
                end
                S_PHYAD: begin
                    shreg_n   = shift_in;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == FIELD_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (shift_in[FIELD_W-1:0] == PHY_ADDR) ? S_REGAD : S_SKIP;
                    end
                end
                S_REGAD: begin
                    shreg_n   = shift_in;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == FIELD_LAST) begin
                        bit_cnt_n = '0;
                        regad_n   = shift_in[FIELD_W-1:0];
                        state_n   = S_TA;
                        rd_arm    = is_read;
                        issue_rd  = is_read & ~bus.reg_cs;
                    end
                end
                S_TA: begin
                    shreg_n   = shift_in;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 6'd1) begin
                        bit_cnt_n = '0;
                        if (is_read) begin
                            state_n = S_RDATA;
                        end else if (shift_in[1:0] == TA_WRITE) begin
                            state_n = S_WDATA;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_PRE;
                        end
                    end
                end
                S_RDATA: bit_cnt_n = bit_cnt + 1'b1;
                S_WDATA: begin
                    shreg_n   = shift_in;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        done_n   = 1'b1;
                        state_n  = S_PRE;
                        err_n    = bus.reg_cs;
                        issue_wr = ~bus.reg_cs;
                    end
                end
                S_SKIP: begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == SKIP_LAST) state_n = S_PRE;
                end
                default: state_n = S_PRE;
            endcase
        end else if (mdc_fall) begin
            if (state == S_TA && is_read && bit_cnt == 6'd1) begin
                mdio_oe_n = 1'b1;
                mdio_o_n  = 1'b0;
            end else if (state == S_RDATA) begin
                if (bit_cnt == '0) begin
                    rd_sample   = 1'b1;
                    timeout_n   = ~rd_valid;
                    mdio_o_n    = rd_word[DATA_W-1];
                    out_shift_n = {rd_word[DATA_W-2:0], 1'b0};
                end else if (bit_cnt == DATA_END) begin
                    mdio_oe_n = 1'b0;
                    mdio_o_n  = 1'b0;
                    done_n    = 1'b1;
                    state_n   = S_PRE;
                end else begin
                    mdio_o_n    = out_shift[DATA_W-1];
                    out_shift_n = {out_shift[DATA_W-2:0], 1'b0};
                end
            end
        end

        if (state_n == S_PRE && state != S_PRE) pre_cnt_n = '0;
    end

    // Read data is only kept if it belongs to the read currently waiting for its D15 slot.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            bus.reg_cs    <= 1'b0;
            bus.reg_wr    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            rd_valid      <= 1'b0;
            rd_want       <= 1'b0;
            rd_data       <= '0;
        end else begin
            if (issue_rd) begin
                bus.reg_cs   <= 1'b1;
                bus.reg_wr   <= 1'b0;
                bus.reg_addr <= shift_in[FIELD_W-1:0];
                rd_want      <= 1'b1;
            end else if (issue_wr) begin
                bus.reg_cs    <= 1'b1;
                bus.reg_wr    <= 1'b1;
                bus.reg_addr  <= regad;
                bus.reg_wdata <= shift_in;
            end else if (bus.reg_cs && bus.reg_ack) begin
                bus.reg_cs <= 1'b0;
                if (rd_want) begin
                    rd_data  <= bus.reg_rdata;
                    rd_valid <= 1'b1;
                end
            end
            if (rd_arm) rd_valid <= 1'b0;
            if (rd_sample) begin
                rd_want  <= 1'b0;
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mdio_resp.sv
// Self-checking bench for mdio_resp: an MDIO master model plus a register-bus scoreboard.
module tb_mdio_resp;
    import mdio_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
    } req_t;

    logic mclk = 1'b0;
    logic reset, mdc, mdio_i;
    logic mdio_o, mdio_oe, frame_done, frame_err, rd_timeout;

    mdio_resp_if bus_if();

    mdio_resp #(.PHY_ADDR(5'd1), .PRE_MIN(32), .SYNC_STG(2)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .mdc        (mdc),
        .mdio_i     (mdio_i),
        .mdio_o     (mdio_o),
        .mdio_oe    (mdio_oe),
        .bus        (bus_if.master),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .rd_timeout (rd_timeout)
    );

    always #5 mclk = ~mclk;

    int vectors = 0;
    int miscompares = 0;
    req_t exp_q[$];
    logic [15:0] rd_exp_q[$];
    int done_cnt = 0, err_cnt = 0, to_cnt = 0, oe_cnt = 0;
    logic cs_prev = 1'b0;
    logic ack_enable = 1'b1;
    int ack_delay = 0;
    int ack_wait = 0;
    logic [15:0] ack_data = 16'h0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_req(input logic wr, input logic [4:0] addr, input logic [15:0] wdata);
        req_t r;
        r.wr = wr;
        r.addr = addr;
        r.wdata = wdata;
        exp_q.push_back(r);
    endtask

    // Pulse counters and the register-request scoreboard.
    always @(negedge mclk) begin
        req_t e;
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (rd_timeout) to_cnt++;
        if (mdio_oe) oe_cnt++;
        if (bus_if.reg_cs && !cs_prev) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_req", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("req_wr", {31'd0, bus_if.reg_wr}, {31'd0, e.wr});
                checkOutput("req_addr", {27'd0, bus_if.reg_addr}, {27'd0, e.addr});
                if (e.wr) checkOutput("req_wdata", {16'd0, bus_if.reg_wdata}, {16'd0, e.wdata});
            end
        end
        cs_prev = bus_if.reg_cs;
    end

    // Register target: acks a held request after ack_delay extra cycles.
    initial begin
        bus_if.reg_ack = 1'b0;
        bus_if.reg_rdata = 16'h0;
        forever begin
            @(posedge mclk);
            #1;
            bus_if.reg_ack = 1'b0;
            if (bus_if.reg_cs && ack_enable && !reset) begin
                if (ack_wait >= ack_delay) begin
                    bus_if.reg_ack = 1'b1;
                    bus_if.reg_rdata = ack_data;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_mclk(input int n);
        repeat (n) @(posedge mclk);
        #2;
    endtask

    // One MDC period: data set while low, responder output sampled just before the rise.
    task automatic applyStimulus(input logic b, output logic smp_o, output logic smp_oe);
        mdio_i = b;
        #80;
        smp_o = mdio_o;
        smp_oe = mdio_oe;
        mdc = 1'b1;
        #80;
        mdc = 1'b0;
    endtask

    task automatic send_field(input logic [15:0] v, input int n);
        logic a, b;
        for (int i = n - 1; i >= 0; i--) applyStimulus(v[i], a, b);
    endtask

    task automatic preamble(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) applyStimulus(1'b1, a, b);
    endtask

    task automatic send_header(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] regad);
        preamble(32);
        send_field(16'h0001, 2);
        send_field({14'd0, op}, 2);
        send_field({11'd0, phy}, 5);
        send_field({11'd0, regad}, 5);
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] regad, input logic [15:0] data);
        send_header(2'b01, phy, regad);
        send_field(16'h0002, 2);
        send_field(data, 16);
        wait_mclk(20);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] regad, input int abort_bit,
                              output logic [15:0] data, output logic ta1_oe, output logic ta2_oe,
                              output logic ta2_o, output logic data_oe);
        logic o, oe;
        data = 16'h0;
        data_oe = 1'b1;
        send_header(2'b10, phy, regad);
        applyStimulus(1'b1, o, ta1_oe);
        applyStimulus(1'b1, ta2_o, ta2_oe);
        for (int i = 0; i < 16; i++) begin
            if (i == abort_bit) begin
                #40;
                return;
            end
            applyStimulus(1'b1, o, oe);
            data = {data[14:0], o};
            data_oe = data_oe & oe;
        end
        wait_mclk(20);
    endtask

    initial begin
        logic [15:0] rdv;
        logic t1oe, t2oe, t2o, doe;
        int d0, e0, t0, o0;

        reset = 1'b1;
        mdc = 1'b0;
        mdio_i = 1'b1;
        #42;
        checkOutput("rst_oe", {31'd0, mdio_oe}, 32'd0);
        checkOutput("rst_o", {31'd0, mdio_o}, 32'd0);
        checkOutput("rst_cs", {31'd0, bus_if.reg_cs}, 32'd0);
        checkOutput("rst_pulses", {29'd0, frame_done, frame_err, rd_timeout}, 32'd0);
        reset = 1'b0;
        wait_mclk(5);

        $display("[TB] write frame to REGAD 0x0A");
        d0 = done_cnt; e0 = err_cnt; o0 = oe_cnt;
        expect_req(1'b1, 5'h0A, 16'hBEEF);
        write_frame(5'd1, 5'h0A, 16'hBEEF);
        checkOutput("wr_done", done_cnt - d0, 32'd1);
        checkOutput("wr_err", err_cnt - e0, 32'd0);
        checkOutput("wr_oe", oe_cnt - o0, 32'd0);
        checkOutput("wr_cs_idle", {31'd0, bus_if.reg_cs}, 32'd0);

        $display("[TB] read frame REGAD 0x03 with delayed ack");
        d0 = done_cnt; t0 = to_cnt;
        ack_delay = 2; ack_data = 16'h1234;
        expect_req(1'b0, 5'h03, 16'h0);
        rd_exp_q.push_back(16'h1234);
        read_frame(5'd1, 5'h03, -1, rdv, t1oe, t2oe, t2o, doe);
        checkOutput("rd_ta1_oe", {31'd0, t1oe}, 32'd0);
        checkOutput("rd_ta2_oe", {31'd0, t2oe}, 32'd1);
        checkOutput("rd_ta2_o", {31'd0, t2o}, 32'd0);
        checkOutput("rd_data_oe", {31'd0, doe}, 32'd1);
        checkOutput("rd_data", {16'd0, rdv}, {16'd0, rd_exp_q.pop_front()});
        checkOutput("rd_oe_off", {31'd0, mdio_oe}, 32'd0);
        checkOutput("rd_done", done_cnt - d0, 32'd1);
        checkOutput("rd_timeout_none", to_cnt - t0, 32'd0);

        $display("[TB] read frame with ack withheld");
        d0 = done_cnt; t0 = to_cnt;
        ack_enable = 1'b0;
        expect_req(1'b0, 5'h05, 16'h0);
        rd_exp_q.push_back(16'hFFFF);
        read_frame(5'd1, 5'h05, -1, rdv, t1oe, t2oe, t2o, doe);
        checkOutput("to_data", {16'd0, rdv}, {16'd0, rd_exp_q.pop_front()});
        checkOutput("to_pulse", to_cnt - t0, 32'd1);
        checkOutput("to_done", done_cnt - d0, 32'd1);
        checkOutput("to_cs_held", {31'd0, bus_if.reg_cs}, 32'd1);
        ack_enable = 1'b1;
        ack_data = 16'h0BAD;
        wait_mclk(10);
        checkOutput("to_late_ack", {31'd0, bus_if.reg_cs}, 32'd0);
        checkOutput("to_pulse_once", to_cnt - t0, 32'd1);

        $display("[TB] frame to foreign PHYAD 0x07, then read to PHYAD 1");
        d0 = done_cnt; o0 = oe_cnt;
        send_header(2'b10, 5'h07, 5'h03);
        preamble(34);
        wait_mclk(5);
        checkOutput("skip_oe", oe_cnt - o0, 32'd0);
        checkOutput("skip_done", done_cnt - d0, 32'd0);
        ack_delay = 1; ack_data = 16'hA5C3;
        expect_req(1'b0, 5'h02, 16'h0);
        rd_exp_q.push_back(16'hA5C3);
        read_frame(5'd1, 5'h02, -1, rdv, t1oe, t2oe, t2o, doe);
        checkOutput("after_skip_data", {16'd0, rdv}, {16'd0, rd_exp_q.pop_front()});
        checkOutput("after_skip_done", done_cnt - d0, 32'd1);

        $display("[TB] short preamble, then illegal opcode");
        d0 = done_cnt; e0 = err_cnt;
        preamble(31);
        send_field(16'h0006, 4);
        send_field(16'h0001, 5);
        send_field(16'h0003, 5);
        preamble(18);
        wait_mclk(5);
        checkOutput("short_pre_done", done_cnt - d0, 32'd0);
        checkOutput("short_pre_err", err_cnt - e0, 32'd0);
        preamble(32);
        send_field(16'h0001, 2);
        send_field(16'h0003, 2);
        preamble(30);
        wait_mclk(5);
        checkOutput("bad_op_err", err_cnt - e0, 32'd1);
        checkOutput("bad_op_done", done_cnt - d0, 32'd0);
        checkOutput("bad_op_no_req", exp_q.size(), 32'd0);

        $display("[TB] reset during RDATA bit 8");
        ack_enable = 1'b0;
        expect_req(1'b0, 5'h04, 16'h0);
        read_frame(5'd1, 5'h04, 7, rdv, t1oe, t2oe, t2o, doe);
        checkOutput("pre_rst_oe", {31'd0, mdio_oe}, 32'd1);
        checkOutput("pre_rst_cs", {31'd0, bus_if.reg_cs}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_oe", {31'd0, mdio_oe}, 32'd0);
        checkOutput("mid_rst_cs", {31'd0, bus_if.reg_cs}, 32'd0);
        #29;
        reset = 1'b0;
        ack_enable = 1'b1;
        wait_mclk(5);
        d0 = done_cnt; t0 = to_cnt;
        ack_delay = 0; ack_data = 16'hC0DE;
        expect_req(1'b0, 5'h04, 16'h0);
        rd_exp_q.push_back(16'hC0DE);
        read_frame(5'd1, 5'h04, -1, rdv, t1oe, t2oe, t2o, doe);
        checkOutput("post_rst_data", {16'd0, rdv}, {16'd0, rd_exp_q.pop_front()});
        checkOutput("post_rst_done", done_cnt - d0, 32'd1);
        checkOutput("post_rst_timeout", to_cnt - t0, 32'd0);

        checkOutput("sb_req_empty", exp_q.size(), 32'd0);
        checkOutput("sb_rd_empty", rd_exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
